// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the N-to-1 round-robin multiplexer.
//   MODE_MANUAL / MODE_RR : encodings of the mode input.
//   ch_idx_w()            : width of a channel index for n channels.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Never returns 0 so a channel-index port always has at least one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority search, purely combinational.
//   req     : per-channel request vector.
//   ptr     : channel with highest priority this cycle.
//   gnt_idx : first requesting channel scanning ptr, ptr+1, ... wrapping.
//   gnt_any : at least one request is present.
module rr_pick
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = ch_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    always_comb begin
        int k;
        k       = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // Scan from the farthest offset back to ptr so the nearest request wins.
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[k]) begin
                gnt_any = 1'b1;
                gnt_idx = SW'(k);
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_rr.sv
// mux_n_to_1_rr: N-to-1 valid/ready multiplexer with a one-entry output
// register, selectable manual or round-robin arbitration.
//   clk, rst   : clock (rising edge), asynchronous active-high reset.
//   in         : N*W channel data, channel k at [k*W +: W].
//   in_valid   : per-channel valid.
//   in_ready   : per-channel accept, one-hot or zero.
//   sel        : channel select used in manual mode.
//   mode       : MODE_MANUAL or MODE_RR.
//   out        : registered selected data.
//   out_ch     : channel index that produced out.
//   out_valid  : out holds a word.
//   out_ready  : downstream accept.
module mux_n_to_1_rr
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int SW = ch_idx_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    output logic [W-1:0]   out,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]          r_out;
    logic [SW-1:0]         r_out_ch;
    logic                  r_out_valid;
    logic [SW-1:0]         r_ptr;

    logic                  w_free;
    logic [(1<<SW)-1:0]    w_valid_pad;
    logic                  w_man_any;
    logic [SW-1:0]         w_rr_idx;
    logic                  w_rr_any;
    logic [SW-1:0]         w_gnt_idx;
    logic                  w_gnt_any;
    logic                  w_xfer;
    logic [W-1:0]          w_data;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_rr_idx),
        .gnt_any (w_rr_any)
    );

    // Register can accept when empty or being drained this cycle.
    assign w_free = ~r_out_valid | out_ready;

    // Zero-padded valid vector so selects beyond N-1 read as "not valid".
    always_comb begin
        w_valid_pad          = '0;
        w_valid_pad[N-1:0]   = in_valid;
    end

    assign w_man_any = (int'(sel) < N) && w_valid_pad[sel];

    always_comb begin
        if (mode == MODE_RR) begin
            w_gnt_idx = w_rr_idx;
            w_gnt_any = w_rr_any;
        end else begin
            w_gnt_idx = sel;
            w_gnt_any = w_man_any;
        end
    end

    // in_ready is forced low during reset, independent of the clock.
    assign w_xfer   = w_gnt_any & w_free & ~rst;
    assign in_ready = w_xfer ? (N'(1) << w_gnt_idx) : '0;
    assign w_data   = in[int'(w_gnt_idx) * W +: W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_free) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out    <= w_data;
                    r_out_ch <= w_gnt_idx;
                end
            end
            // Manual-mode transfers leave the rotation point untouched.
            if (w_xfer && (mode == MODE_RR)) begin
                r_ptr <= (w_gnt_idx == SW'(N - 1)) ? '0 : w_gnt_idx + SW'(1);
            end
        end
    end

    assign out       = r_out;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
module tb_mux_n_to_1_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] in_bus;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic           mode;
    logic [W-1:0]   out;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;

    int n_vec;
    int n_err;

    mux_n_to_1_rr #(
        .N  (N),
        .W  (W),
        .SW (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_bus),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out       (out),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected data for channel k with the standard input pattern.
    function automatic logic [7:0] std_data(input int k);
        case (k)
            0: return 8'h11;
            1: return 8'h22;
            2: return 8'h33;
            default: return 8'h44;
        endcase
    endfunction

    int exp_rr  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_sp  [4] = '{1, 3, 1, 3};

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_bus    = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid  = 4'hF;
        sel       = 2'd0;
        mode      = 1'b1;
        out_ready = 1'b1;

        // Reset state, with requests pending.
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out",       32'(out),       32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);

        // Release between edges; manual select of channel 2.
        @(negedge clk);
        rst  = 1'b0;
        mode = 1'b0;
        sel  = 2'd2;
        #1;
        chk("man_in_ready", 32'(in_ready), 32'b0100);
        step();
        chk("man_out",       32'(out),       32'h33);
        chk("man_out_ch",    32'(out_ch),    32'd2);
        chk("man_out_valid", 32'(out_valid), 32'd1);

        // Round-robin with all channels valid; ptr still 0 after manual.
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_ch",    32'(out_ch),    32'(exp_rr[i]));
            chk("rr_data",  32'(out),       32'(std_data(exp_rr[i])));
            chk("rr_valid", 32'(out_valid), 32'd1);
        end

        // Sparse round-robin, ptr wrapped back to 0.
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sparse_ch", 32'(out_ch), 32'(exp_sp[i]));
        end
        in_valid = 4'hF;
        step();
        chk("sparse_wrap_ch", 32'(out_ch), 32'd0);

        // Stall holding channel 0's word while inputs change.
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_bus   = {8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)};
            in_valid = (i == 1) ? 4'b0101 : 4'hF;
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("stall_out",       32'(out),       32'h11);
            chk("stall_out_ch",    32'(out_ch),    32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_bus    = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid  = 4'hF;
        out_ready = 1'b1;
        step();
        chk("unstall_ch",  32'(out_ch), 32'd1);
        chk("unstall_out", 32'(out),    32'h22);

        // Mode switch: ptr is 2, two manual transfers from channel 0.
        mode = 1'b0;
        sel  = 2'd0;
        step();
        chk("msw_man1_ch", 32'(out_ch), 32'd0);
        step();
        chk("msw_man2_ch", 32'(out_ch), 32'd0);
        mode = 1'b1;
        step();
        chk("msw_rr_ch",  32'(out_ch), 32'd2);
        chk("msw_rr_out", 32'(out),    32'h33);

        // Stall (ptr now 3), then asynchronous reset between edges.
        out_ready = 1'b0;
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out",       32'(out),       32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_rst_ch",    32'(out_ch),    32'd0);
        chk("post_rst_out",   32'(out),       32'h11);
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        // Idle: valid drops, data and channel keep last value.
        in_valid = 4'h0;
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_out",   32'(out),       32'h11);
        chk("idle_ch",    32'(out_ch),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
